// File: rtl/fft_pkg.sv
// Shared defaults, write-side state encoding and the address bit-reversal
// helper for the 32-point FFT output reorder buffer.
package fft_pkg;

  localparam int unsigned FFT_LAYER  = 5;
  localparam int unsigned FFT_N      = 32;
  localparam int unsigned FFT_WIDTH  = 32;
  localparam int unsigned BITREV_MAX = 16;

  typedef enum logic {
    WR_IDLE   = 1'b0,
    WR_ACTIVE = 1'b1
  } wr_state_e;

  // Reverse the low 'bits' bits of v; bits above that return as zero.
  function automatic logic [BITREV_MAX-1:0] bitrev(input logic [BITREV_MAX-1:0] v,
                                                   input int unsigned bits);
    logic [BITREV_MAX-1:0] r;
    r = {<<{v}};
    return r >> (BITREV_MAX - bits);
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank simple dual-port RAM holding complex words {real, imag};
// the bank is the address MSB, and the read port is registered.
module fft_pingpong_ram
  import fft_pkg::*;
#(
  parameter int unsigned LAYER = FFT_LAYER,
  parameter int unsigned WIDTH = FFT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [LAYER:0]     waddr,
  input  logic [2*WIDTH-1:0] wdata,
  input  logic               re,
  input  logic [LAYER:0]     raddr,
  output logic [2*WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 2 << LAYER;

  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [2*WIDTH-1:0] rdata_q;

  // Storage is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read register holds its value while no read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fft_reorder_32.sv
// Converts a bit-reversed FFT output frame to natural order through a
// ping-pong buffer, with a fixed two-cycle latency from the accepting over.
module fft_reorder_32
  import fft_pkg::*;
#(
  parameter int unsigned LAYER = FFT_LAYER,
  parameter int unsigned WIDTH = FFT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             over,
  input  logic [WIDTH-1:0] data_in_real,
  input  logic [WIDTH-1:0] data_in_img,
  output logic [WIDTH-1:0] data_out_real,
  output logic [WIDTH-1:0] data_out_img,
  output logic             valid_next,
  output logic             start_next,
  output logic             end_next,
  output logic             frame_err
);

  localparam int unsigned      N    = 1 << LAYER;
  localparam logic [LAYER-1:0] LAST = LAYER'(N - 1);

  wr_state_e        wr_state_q, wr_state_d;
  logic [LAYER-1:0] wr_cnt_q, wr_cnt_d;
  logic             wr_bank_q, wr_bank_d;
  logic             err_q, err_d;
  logic             rd_active_q, rd_active_d;
  logic [LAYER-1:0] rd_cnt_q, rd_cnt_d;
  logic             rd_bank_q, rd_bank_d;
  logic             valid_q, valid_d;
  logic             start_next_q, start_next_d;
  logic             end_next_q, end_next_d;

  logic             accept;
  logic             ram_we;
  logic [LAYER-1:0] wr_idx;
  logic [LAYER:0]   ram_waddr;
  logic [LAYER:0]   ram_raddr;
  logic [2*WIDTH-1:0] ram_rdata;

  // Write side: frame tracking, drop detection and bank hand-off.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    wr_bank_d  = wr_bank_q;
    err_d      = 1'b0;
    accept     = 1'b0;
    ram_we     = 1'b0;
    wr_idx     = wr_cnt_q;
    case (wr_state_q)
      WR_IDLE: begin
        if (start) begin
          if (over) begin
            err_d = 1'b1;
          end else begin
            ram_we     = 1'b1;
            wr_idx     = '0;
            wr_cnt_d   = LAYER'(1);
            wr_state_d = WR_ACTIVE;
          end
        end
      end
      WR_ACTIVE: begin
        if (over && (wr_cnt_q == LAST)) begin
          // Last sample lands in the finished bank; a coincident start opens
          // the next frame in the other bank from the following cycle.
          accept     = 1'b1;
          ram_we     = 1'b1;
          wr_bank_d  = ~wr_bank_q;
          wr_cnt_d   = '0;
          wr_state_d = start ? WR_ACTIVE : WR_IDLE;
        end else if (start) begin
          err_d = 1'b1;
          if (over) begin
            wr_cnt_d   = '0;
            wr_state_d = WR_IDLE;
          end else begin
            ram_we   = 1'b1;
            wr_idx   = '0;
            wr_cnt_d = LAYER'(1);
          end
        end else if (over || (wr_cnt_q == LAST)) begin
          err_d      = 1'b1;
          wr_cnt_d   = '0;
          wr_state_d = WR_IDLE;
        end else begin
          ram_we   = 1'b1;
          wr_cnt_d = wr_cnt_q + LAYER'(1);
        end
      end
      default: begin
        wr_state_d = WR_IDLE;
        wr_cnt_d   = '0;
      end
    endcase
  end

  // Read side: sweep natural-order addresses of the handed-over bank.
  always_comb begin
    rd_active_d  = rd_active_q;
    rd_cnt_d     = rd_cnt_q;
    rd_bank_d    = rd_bank_q;
    valid_d      = rd_active_q;
    start_next_d = rd_active_q && (rd_cnt_q == '0);
    end_next_d   = rd_active_q && (rd_cnt_q == LAST);
    if (accept) begin
      rd_active_d = 1'b1;
      rd_cnt_d    = '0;
      rd_bank_d   = wr_bank_q;
    end else if (rd_active_q) begin
      rd_cnt_d = rd_cnt_q + LAYER'(1);
      if (rd_cnt_q == LAST) begin
        rd_active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q   <= WR_IDLE;
      wr_cnt_q     <= '0;
      wr_bank_q    <= 1'b0;
      err_q        <= 1'b0;
      rd_active_q  <= 1'b0;
      rd_cnt_q     <= '0;
      rd_bank_q    <= 1'b0;
      valid_q      <= 1'b0;
      start_next_q <= 1'b0;
      end_next_q   <= 1'b0;
    end else begin
      wr_state_q   <= wr_state_d;
      wr_cnt_q     <= wr_cnt_d;
      wr_bank_q    <= wr_bank_d;
      err_q        <= err_d;
      rd_active_q  <= rd_active_d;
      rd_cnt_q     <= rd_cnt_d;
      rd_bank_q    <= rd_bank_d;
      valid_q      <= valid_d;
      start_next_q <= start_next_d;
      end_next_q   <= end_next_d;
    end
  end

  assign ram_waddr = {wr_bank_q, LAYER'(bitrev(BITREV_MAX'(wr_idx), LAYER))};
  assign ram_raddr = {rd_bank_q, rd_cnt_q};

  fft_pingpong_ram #(
    .LAYER (LAYER),
    .WIDTH (WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata ({data_in_real, data_in_img}),
    .re    (rd_active_q),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign data_out_real = ram_rdata[2*WIDTH-1:WIDTH];
  assign data_out_img  = ram_rdata[WIDTH-1:0];
  assign valid_next    = valid_q;
  assign start_next    = start_next_q;
  assign end_next      = end_next_q;
  assign frame_err     = err_q;

endmodule

// File: tb/tb_fft_reorder_32.sv
// Bench for fft_reorder_32: frame-level vector table plus hand sequences,
// with a queue-based reorder model predicting every output cycle.
module tb_fft_reorder_32;

  localparam int DEPTH = 4096;

  logic        clk;
  logic        rst;
  logic        start;
  logic        over;
  logic [31:0] data_in_real;
  logic [31:0] data_in_img;
  logic [31:0] data_out_real;
  logic [31:0] data_out_img;
  logic        valid_next;
  logic        start_next;
  logic        end_next;
  logic        frame_err;

  fft_reorder_32 dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .over          (over),
    .data_in_real  (data_in_real),
    .data_in_img   (data_in_img),
    .data_out_real (data_out_real),
    .data_out_img  (data_out_img),
    .valid_next    (valid_next),
    .start_next    (start_next),
    .end_next      (end_next),
    .frame_err     (frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] re;
    logic [31:0] im;
  } samp_t;

  typedef struct {
    int len;
    int over_at;
    int restart_at;
    int pat;
    int exp_valid;
    int exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Expected output timeline, indexed by cycle number.
  bit          exp_v   [DEPTH];
  bit          exp_s   [DEPTH];
  bit          exp_e   [DEPTH];
  bit          exp_err [DEPTH];
  logic [31:0] exp_r   [DEPTH];
  logic [31:0] exp_i   [DEPTH];

  logic [31:0] last_r = '0;
  logic [31:0] last_i = '0;
  logic        prev_rst = 1'b1;
  int          vcount = 0;
  int          ecount = 0;
  int          cur_run = 0;
  int          max_run = 0;

  samp_t frame_q[$];
  bit    model_active = 1'b0;

  function automatic int brev5(input int v);
    int r = 0;
    int x = v;
    for (int b = 0; b < 5; b++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_accept(input int c);
    for (int j = 0; j < 32; j++) begin
      if (c + 2 + j < DEPTH) begin
        exp_v[c+2+j] = 1'b1;
        exp_s[c+2+j] = (j == 0);
        exp_e[c+2+j] = (j == 31);
        exp_r[c+2+j] = frame_q[brev5(j)].re;
        exp_i[c+2+j] = frame_q[brev5(j)].im;
      end
    end
  endtask

  task automatic model_err(input int c);
    if (c + 1 < DEPTH) exp_err[c+1] = 1'b1;
  endtask

  // A frame is a run of samples from its start; it survives only if its
  // 32nd sample carries over.
  task automatic model_step(input int c, input bit s, input bit o, input samp_t smp);
    if (s && o && model_active && frame_q.size() == 31) begin
      frame_q.push_back(smp);
      model_accept(c);
      frame_q.delete();
    end else if (s) begin
      if (model_active || o) model_err(c);
      frame_q.delete();
      if (o) begin
        model_active = 1'b0;
      end else begin
        frame_q.push_back(smp);
        model_active = 1'b1;
      end
    end else if (model_active) begin
      frame_q.push_back(smp);
      if (frame_q.size() == 32) begin
        if (o) model_accept(c);
        else model_err(c);
        model_active = 1'b0;
        frame_q.delete();
      end else if (o) begin
        model_err(c);
        model_active = 1'b0;
        frame_q.delete();
      end
    end
  endtask

  task automatic model_reset(input int c);
    for (int t = c + 1; t < c + 48 && t < DEPTH; t++) begin
      exp_v[t] = 1'b0; exp_s[t] = 1'b0; exp_e[t] = 1'b0; exp_err[t] = 1'b0;
    end
    model_active = 1'b0;
    frame_q.delete();
  endtask

  task automatic monitor();
    logic [31:0] er;
    logic [31:0] ei;
    if (prev_rst) begin
      last_r = '0;
      last_i = '0;
    end
    if (exp_v[cyc]) begin
      er = exp_r[cyc];
      ei = exp_i[cyc];
      last_r = er;
      last_i = ei;
    end else begin
      er = last_r;
      ei = last_i;
    end
    chk("valid_next", 32'(valid_next), 32'(exp_v[cyc]));
    chk("start_next", 32'(start_next), 32'(exp_s[cyc]));
    chk("end_next",   32'(end_next),   32'(exp_e[cyc]));
    chk("frame_err",  32'(frame_err),  32'(exp_err[cyc]));
    chk("data_out_real", data_out_real, er);
    chk("data_out_img",  data_out_img,  ei);
    if (valid_next === 1'b1) begin
      vcount++;
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
    end else begin
      cur_run = 0;
    end
    if (frame_err === 1'b1) ecount++;
  endtask

  task automatic tick();
    @(negedge clk);
    if (cyc >= 1) monitor();
    prev_rst = rst;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drive(input bit s, input bit o, input samp_t smp);
    start = s;
    over = o;
    data_in_real = smp.re;
    data_in_img = smp.im;
    model_step(cyc, s, o, smp);
    tick();
  endtask

  task automatic idle(input int n);
    samp_t junk;
    for (int i = 0; i < n; i++) begin
      junk.re = $urandom;
      junk.im = $urandom;
      drive(1'b0, 1'b0, junk);
    end
  endtask

  function automatic samp_t make_samp(input int pat, input int k);
    samp_t s;
    case (pat)
      0: begin s.re = 32'(k); s.im = 32'(-k); end
      1: begin s.re = $urandom; s.im = $urandom; end
      default: begin s.re = (k == 0) ? 32'd1 : 32'd0; s.im = '0; end
    endcase
    return s;
  endfunction

  task automatic send_frame(input int len, input int over_at, input int restart_at, input int pat);
    int k;
    for (int i = 0; i < len; i++) begin
      k = (restart_at >= 0 && i >= restart_at) ? i - restart_at : i;
      drive((i == 0) || (i == restart_at), (i == over_at), make_samp(pat, k));
    end
  endtask

  vec_t vecs[8];

  initial begin
    int v0;
    int e0;
    samp_t smp;

    vecs[0] = '{len: 32, over_at: 31, restart_at: -1, pat: 0, exp_valid: 32, exp_err: 0};
    vecs[1] = '{len: 21, over_at: 20, restart_at: -1, pat: 1, exp_valid: 0,  exp_err: 1};
    vecs[2] = '{len: 32, over_at: 31, restart_at: -1, pat: 1, exp_valid: 32, exp_err: 0};
    vecs[3] = '{len: 42, over_at: 41, restart_at: 10, pat: 1, exp_valid: 32, exp_err: 1};
    vecs[4] = '{len: 32, over_at: 31, restart_at: -1, pat: 2, exp_valid: 32, exp_err: 0};
    vecs[5] = '{len: 32, over_at: -1, restart_at: -1, pat: 1, exp_valid: 0,  exp_err: 1};
    vecs[6] = '{len: 1,  over_at: 0,  restart_at: -1, pat: 1, exp_valid: 0,  exp_err: 1};
    vecs[7] = '{len: 32, over_at: 31, restart_at: -1, pat: 0, exp_valid: 32, exp_err: 0};

    rst = 1'b1;
    start = 1'b0;
    over = 1'b0;
    data_in_real = '0;
    data_in_img = '0;
    tick();
    tick();
    tick();
    rst = 1'b0;
    idle(4);

    foreach (vecs[n]) begin
      v0 = vcount;
      e0 = ecount;
      send_frame(vecs[n].len, vecs[n].over_at, vecs[n].restart_at, vecs[n].pat);
      idle(40);
      chk($sformatf("vec%0d_valid_count", n), 32'(vcount - v0), 32'(vecs[n].exp_valid));
      chk($sformatf("vec%0d_err_count", n),   32'(ecount - e0), 32'(vecs[n].exp_err));
    end

    // Three frames streamed with over of one frame coinciding with start of the next.
    v0 = vcount;
    e0 = ecount;
    max_run = 0;
    for (int i = 0; i < 96; i++) begin
      smp.re = $urandom;
      smp.im = $urandom;
      drive((i == 0) || (i == 31) || (i == 63), (i == 31) || (i == 63) || (i == 95), smp);
    end
    idle(40);
    chk("stream_valid_count", 32'(vcount - v0), 32'd96);
    chk("stream_valid_run",   32'(max_run),     32'd96);
    chk("stream_err_count",   32'(ecount - e0), 32'd0);

    // Reset during the fifth output sample, then a clean frame.
    v0 = vcount;
    send_frame(32, 31, -1, 1);
    idle(5);
    rst = 1'b1;
    model_reset(cyc);
    smp.re = '0;
    smp.im = '0;
    start = 1'b0;
    over = 1'b0;
    tick();
    rst = 1'b0;
    chk("reset_out_valid", 32'(valid_next), 32'd0);
    chk("reset_out_real",  data_out_real,   32'd0);
    chk("reset_out_img",   data_out_img,    32'd0);
    idle(40);
    chk("reset_valid_count", 32'(vcount - v0), 32'd5);
    v0 = vcount;
    send_frame(32, 31, -1, 1);
    idle(40);
    chk("post_reset_valid_count", 32'(vcount - v0), 32'd32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_reorder_32.md
FFT_REORDER_32 -- requirements
Module: fft_reorder_32

Interface
REQ-001 SHALL have parameter LAYER, default 5; log2 of frame length N = 2^LAYER = 32.
REQ-002 SHALL have parameter WIDTH, default 32; bit width of each real and imaginary word.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  pulse marking the first bit-reversed sample of an FFT output frame.
REQ-006 SHALL have port over  input  1  pulse marking the last sample of the frame.
REQ-007 SHALL have port data_in_real / data_in_img  input  WIDTH each  FFT result, bit-reversed order, one sample per cycle from start to over inclusive.
REQ-008 SHALL have port data_out_real / data_out_img  output  WIDTH each  result in natural order.
REQ-009 SHALL have port valid_next  output  1  high on every cycle data_out carries a sample.
REQ-010 SHALL have port start_next / end_next  output  1 each  pulses on the first and last natural-order output sample.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse when an input frame is dropped.

Function
REQ-012 SHALL hold two banks of N complex words (ping-pong); write bank and read bank always differ.
REQ-013 Write side SHALL be IDLE until start; on start, sample 0 goes to wr_cnt = 0 and wr_cnt increments by 1 on each following cycle.
REQ-014 Sample at wr_cnt SHALL be stored at address bitrev(wr_cnt), LAYER bits.
REQ-015 A frame SHALL be accepted only if over coincides with wr_cnt = N-1; acceptance hands the bank to the read side and toggles the write bank.
REQ-016 over with wr_cnt != N-1, or wr_cnt reaching N-1 without over, SHALL drop the frame, pulse frame_err the next cycle, and return the write side to IDLE without toggling the bank.
REQ-017 start while a frame is being written SHALL drop the partial frame (frame_err pulse) and restart at wr_cnt = 0 in the same bank, on the same cycle.
REQ-018 start and over in the same cycle with wr_cnt = N-1 SHALL accept the current frame and begin a new one in the other bank.
REQ-019 Read side SHALL issue address 0 the cycle after acceptance and then addresses 1..N-1 on consecutive cycles; RAM read is registered.
REQ-020 Latency SHALL be fixed: start_next occurs 2 cycles after the accepting over cycle, and end_next occurs N-1 cycles after start_next.
REQ-021 valid_next SHALL be high for exactly N consecutive cycles per accepted frame.
REQ-022 Back-to-back frames with no idle cycles SHALL stream with no gap in valid_next and no loss.
REQ-023 When valid_next is low, data_out SHALL hold its last value.

Reset
REQ-024 On rst high, all state SHALL reset: write side IDLE, wr_cnt = 0, write bank = 0, read side idle.
REQ-025 The same cycle SHALL drive valid_next, start_next, end_next and frame_err to 0 and data_out_real / data_out_img to 0.
REQ-026 RAM contents SHALL NOT require reset.
REQ-027 Reset mid-frame SHALL abort any write or read in progress with no further outputs.

Structure
REQ-028 Package fft_pkg SHALL hold LAYER, N and WIDTH defaults and a bitrev function.
REQ-029 One sub-module, fft_pingpong_ram, SHALL hold the dual-bank simple dual-port RAM: 2*N x 2*WIDTH, one write port, one registered read port.

Verification
REQ-030 Write real = k and imag = -k at sequence index k (k = 0..31), start at k = 0, over at k = 31 -> output index j carries real = bitrev5(j); start_next 2 cycles after over; 32 valid cycles.
REQ-031 Three frames with no idle cycles (over of frame n in the same cycle as start of frame n+1) -> 96 contiguous valid_next cycles, each frame correctly reordered.
REQ-032 Stimulus: over at wr_cnt = 20 -> frame_err single pulse, no valid_next; the next full frame is reordered correctly.
REQ-033 Stimulus: start re-asserted at wr_cnt = 10 -> frame_err pulse; the restarted frame is output intact, 2 cycles after its over.
REQ-034 Stimulus: rst asserted at the 5th output sample -> next cycle all outputs 0; a following frame completes normally.
REQ-035 Stimulus: an impulse (real = 1 at index 0) -> output real = 1 only at j = 0.
